ins_prefetch_unit: RTL and testbench

Upstream stage of the instruction fetch unit. It owns the program counter and issues single-word reads to instruction memory. Returned words are buffered in a small prefetch FIFO. The FIFO head is presented to the instruction checker with a wait_for_next flag. The checker's pc_choice output either keeps sequential fetch or redirects the PC, which flushes the FIFO.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ins_fifo.sv | 72 +++++++
 rtl/ins_prefetch_unit.sv | 123 ++++++++++++
 tb/tb_ins_prefetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared instruction-fetch definitions: fetch FSM encoding and halt-word decode.
// Used by the prefetch unit, the instruction checker and the control unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;
    localparam logic [1:0] SUB_STOP    = 2'b11;
    localparam logic [1:0] SUB_END     = 2'b00;

    // Both stop and end words freeze fetching until resumed or redirected.
    function automatic logic is_halt_word(input logic [5:0] opcode, input logic [1:0] sub);
        return (opcode == HALT_OPCODE) && ((sub == SUB_STOP) || (sub == SUB_END));
    endfunction

endpackage

// File: rtl/ins_fifo.sv
// Small synchronous FIFO with flush; head word is read straight from storage
// so a pushed word is visible the cycle after the push.
module ins_fifo #(
    parameter int width = 32,
    parameter int depth = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push_in,
    input  logic [width-1:0]           data_in,
    input  logic                       pop_in,
    input  logic                       flush_in,
    output logic [width-1:0]           data_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic [$clog2(depth):0]     count_out
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_out = (count_q == '0);
    assign full_out  = (count_q == CW'(depth));
    assign count_out = count_q;

    // Pops on an empty FIFO are ignored; a push into a full FIFO only lands
    // when a pop frees the head slot in the same cycle.
    assign pop_ok  = pop_in && !empty_out;
    assign push_ok = push_in && (!full_out || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !flush_in) mem_q[wr_ptr_q] <= data_in;
    end

    // Force zero while empty so stale words never leak after a flush.
    assign data_out = empty_out ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ins_prefetch_unit.sv
// Instruction prefetch: owns the PC, issues one outstanding read at a time,
// buffers returned words and presents the head to the instruction checker.
module ins_prefetch_unit
    import ifu_pkg::*;
#(
    parameter int                    bus_width  = 32,
    parameter int                    addr_width = 16,
    parameter int                    fifo_depth = 4,
    parameter logic [addr_width-1:0] reset_pc   = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pc_choice_in,
    input  logic [addr_width-1:0] target_in,
    input  logic                  resume_in,
    output logic                  mem_req_out,
    output logic [addr_width-1:0] mem_addr_out,
    input  logic                  mem_ack_in,
    input  logic [bus_width-1:0]  mem_data_in,
    output logic [bus_width-1:0]  ins_out,
    output logic                  wait_for_next_out,
    input  logic                  ins_taken_in,
    output logic                  halted_out
);

    localparam int CW = $clog2(fifo_depth) + 1;

    fetch_state_t          state_q, state_d;
    logic [addr_width-1:0] pc_q, pc_d;
    logic                  mem_req_q, mem_req_d;
    logic [addr_width-1:0] mem_addr_q, mem_addr_d;
    logic                  halted_q, halted_d;

    logic                  redirect;
    logic                  push;
    logic                  pop_ok;
    logic                  halt_word;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         count_after;

    assign redirect  = !pc_choice_in;
    // An ack that coincides with a redirect belongs to the abandoned stream.
    assign push      = (state_q == REQ) && mem_ack_in && !redirect;
    assign pop_ok    = ins_taken_in && !fifo_empty;
    assign halt_word = is_halt_word(mem_data_in[bus_width-1 -: 6], mem_data_in[bus_width-7 -: 2]);

    // Occupancy after this cycle's push/pop; a new request needs a slot here.
    assign count_after = fifo_count + CW'(push) - CW'(pop_ok);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect) begin
            state_d = IDLE;
            pc_d    = target_in;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_full || pop_ok) state_d = REQ;
                end
                REQ: begin
                    if (mem_ack_in) begin
                        pc_d = pc_q + addr_width'(1);
                        if (halt_word)
                            state_d = HALT;
                        else if (count_after < CW'(fifo_depth))
                            state_d = REQ;
                        else
                            state_d = IDLE;
                    end
                end
                HALT: begin
                    if (resume_in) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        mem_req_d  = (state_d == REQ);
        mem_addr_d = mem_req_d ? pc_d : '0;
        halted_d   = (state_d == HALT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= reset_pc;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            halted_q   <= halted_d;
        end
    end

    assign mem_req_out  = mem_req_q;
    assign mem_addr_out = mem_addr_q;
    assign halted_out   = halted_q;

    ins_fifo #(
        .width (bus_width),
        .depth (fifo_depth)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push_in   (push),
        .data_in   (mem_data_in),
        .pop_in    (ins_taken_in),
        .flush_in  (redirect),
        .data_out  (ins_out),
        .full_out  (fifo_full),
        .empty_out (fifo_empty),
        .count_out (fifo_count)
    );

    assign wait_for_next_out = fifo_empty;

endmodule

// File: tb/tb_ins_prefetch_unit.sv
// Directed bench for ins_prefetch_unit with a zero-wait memory model
// (memory[i] = i + 100) and a recorder of consumed instructions.
module tb_ins_prefetch_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        pc_choice_in = 1'b1;
    logic [15:0] target_in = '0;
    logic        resume_in = 1'b0;
    logic        mem_req_out;
    logic [15:0] mem_addr_out;
    logic        mem_ack_in = 1'b0;
    logic [31:0] mem_data_in = '0;
    logic [31:0] ins_out;
    logic        wait_for_next_out;
    logic        ins_taken_in = 1'b0;
    logic        halted_out;

    int          n_chk = 0;
    int          n_err = 0;
    logic        mem_en = 1'b0;
    logic        halt5 = 1'b0;
    logic [15:0] addr_log [$];
    logic [31:0] popped [$];

    ins_prefetch_unit #(
        .bus_width  (32),
        .addr_width (16),
        .fifo_depth (4),
        .reset_pc   (16'h0000)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .pc_choice_in      (pc_choice_in),
        .target_in         (target_in),
        .resume_in         (resume_in),
        .mem_req_out       (mem_req_out),
        .mem_addr_out      (mem_addr_out),
        .mem_ack_in        (mem_ack_in),
        .mem_data_in       (mem_data_in),
        .ins_out           (ins_out),
        .wait_for_next_out (wait_for_next_out),
        .ins_taken_in      (ins_taken_in),
        .halted_out        (halted_out)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (halt5 && a == 16'd5) return 32'hFF00_0000;
        return {16'h0, a} + 32'd100;
    endfunction

    // Memory answers a request in the same cycle; the recorder logs what the
    // consumer takes at the coming edge.
    always @(negedge clock) begin
        if (mem_en && mem_req_out) begin
            mem_ack_in  = 1'b1;
            mem_data_in = mem_word(mem_addr_out);
            addr_log.push_back(mem_addr_out);
        end else begin
            mem_ack_in  = 1'b0;
        end
        if (ins_taken_in && !wait_for_next_out) popped.push_back(ins_out);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        pc_choice_in = 1'b1;
        resume_in    = 1'b0;
        ins_taken_in = 1'b0;
        mem_en       = 1'b0;
        halt5        = 1'b0;
        tick(2);
        addr_log.delete();
        popped.delete();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_req",    32'(mem_req_out), 32'd0);
        chk("rst_addr",   32'(mem_addr_out), 32'd0);
        chk("rst_ins",    ins_out, 32'd0);
        chk("rst_wait",   32'(wait_for_next_out), 32'd1);
        chk("rst_halted", 32'(halted_out), 32'd0);

        // Sequential fetch with the consumer always taking.
        do_reset();
        mem_en = 1'b1;
        ins_taken_in = 1'b1;
        tick();
        chk("t1_req",   32'(mem_req_out), 32'd1);
        chk("t1_addr0", 32'(mem_addr_out), 32'd0);
        chk("t1_wait0", 32'(wait_for_next_out), 32'd1);
        tick();
        chk("t1_wait",  32'(wait_for_next_out), 32'd0);
        chk("t1_ins0",  ins_out, 32'd100);
        chk("t1_addr1", 32'(mem_addr_out), 32'd1);
        tick(10);
        chk("t1_npop", 32'(popped.size() >= 6 && addr_log.size() >= 6), 32'd1);
        if (popped.size() >= 6 && addr_log.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("t1_pop",  popped[k], 32'(100 + k));
                chk("t1_alog", 32'(addr_log[k]), 32'(k));
            end
        end

        // Consumer stalled: exactly fifo_depth requests, then one pop frees a slot.
        do_reset();
        mem_en = 1'b1;
        tick(10);
        chk("t2_nreq",  32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) chk("t2_last", 32'(addr_log[3]), 32'd3);
        chk("t2_req",   32'(mem_req_out), 32'd0);
        chk("t2_head",  ins_out, 32'd100);
        ins_taken_in = 1'b1;
        tick();
        ins_taken_in = 1'b0;
        chk("t2_req4",  32'(mem_req_out), 32'd1);
        chk("t2_addr4", 32'(mem_addr_out), 32'd4);
        chk("t2_head1", ins_out, 32'd101);

        // Halt word at address 5, then resume.
        do_reset();
        halt5 = 1'b1;
        mem_en = 1'b1;
        ins_taken_in = 1'b1;
        i = 0;
        while (!halted_out && i < 20) begin
            tick();
            i++;
        end
        chk("t3_halted", 32'(halted_out), 32'd1);
        chk("t3_noreq",  32'(mem_req_out), 32'd0);
        tick(3);
        chk("t3_req_off", 32'(mem_req_out), 32'd0);
        chk("t3_nreq",    32'(addr_log.size()), 32'd6);
        chk("t3_npop",    32'(popped.size()), 32'd6);
        if (popped.size() == 6) chk("t3_haltword", popped[5], 32'hFF00_0000);
        chk("t3_drained", 32'(wait_for_next_out), 32'd1);
        resume_in = 1'b1;
        tick();
        resume_in = 1'b0;
        chk("t3_unhalt", 32'(halted_out), 32'd0);
        tick();
        chk("t3_req6",  32'(mem_req_out), 32'd1);
        chk("t3_addr6", 32'(mem_addr_out), 32'd6);

        // Redirect with three words buffered and a request being acked.
        do_reset();
        mem_en = 1'b1;
        tick(4);
        chk("t4_pre_req",  32'(mem_req_out), 32'd1);
        chk("t4_pre_addr", 32'(mem_addr_out), 32'd3);
        chk("t4_pre_head", ins_out, 32'd100);
        pc_choice_in = 1'b0;
        target_in = 16'h0040;
        tick();
        pc_choice_in = 1'b1;
        chk("t4_flush_wait", 32'(wait_for_next_out), 32'd1);
        chk("t4_flush_ins",  ins_out, 32'd0);
        chk("t4_flush_req",  32'(mem_req_out), 32'd0);
        tick();
        chk("t4_req",  32'(mem_req_out), 32'd1);
        chk("t4_addr", 32'(mem_addr_out), 32'h0040);
        tick();
        chk("t4_head", ins_out, 32'h0000_00A4);
        chk("t4_wait", 32'(wait_for_next_out), 32'd0);

        // PC wrap at the top of the address space.
        do_reset();
        mem_en = 1'b1;
        ins_taken_in = 1'b1;
        pc_choice_in = 1'b0;
        target_in = 16'hFFFF;
        tick();
        pc_choice_in = 1'b1;
        tick();
        chk("t5_req",   32'(mem_req_out), 32'd1);
        chk("t5_addr",  32'(mem_addr_out), 32'h0000_FFFF);
        tick();
        chk("t5_wrap",  32'(mem_addr_out), 32'd0);
        chk("t5_req2",  32'(mem_req_out), 32'd1);
        chk("t5_head",  ins_out, 32'h0001_0063);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        mem_en = 1'b1;
        ins_taken_in = 1'b1;
        tick(3);
        chk("t6_busy", 32'(mem_req_out), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_req",    32'(mem_req_out), 32'd0);
        chk("t6_addr",   32'(mem_addr_out), 32'd0);
        chk("t6_ins",    ins_out, 32'd0);
        chk("t6_wait",   32'(wait_for_next_out), 32'd1);
        chk("t6_halted", 32'(halted_out), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6_restart_req",  32'(mem_req_out), 32'd1);
        chk("t6_restart_addr", 32'(mem_addr_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
